// File: rtl/rpn_stack_exec_if.sv
// Command channel between the key/switch front end and the RPN stack executor.
// The front end is the master; the executor is the slave.
interface rpn_stack_exec_if #(
    parameter int unsigned DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              done;
    logic [1:0]        err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, done, err
    );
endinterface

// File: rtl/rpn_stack_exec.sv
// RPN stack execution controller: one command at a time, owns the stack pointer and a TOS cache.
// Define RPN_MUL_EN to enable opcode 100 as MUL; otherwise that opcode reports illegal.
module rpn_stack_exec #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    rpn_stack_exec_if.slave   cmd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] tos,
    output logic [ADDR_W:0]   depth,
    output logic              carry
);

`ifdef RPN_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    localparam logic [ADDR_W:0] DepthFull = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] DepthOne  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DepthTwo  = (ADDR_W+1)'(2);

    typedef enum logic [2:0] {
        StIdle, StRd, StExec, StWr, StDone
    } state_e;

    typedef enum logic [2:0] {
        OpPush, OpPop, OpAdd, OpSub, OpMul, OpAnd, OpOr, OpDup
    } op_e;

    typedef enum logic [1:0] {
        ErrOk, ErrUnder, ErrOver, ErrIllegal
    } err_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d, op_in;
    err_e              err_q, err_d;
    logic [ADDR_W:0]   depth_q, depth_d;
    logic [DATA_W-1:0] tos_q, tos_d;
    logic              carry_q, carry_d;
    logic [ADDR_W-1:0] addr_q, addr_d, nos_addr;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   sum;
`ifdef RPN_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    assign op_in    = op_e'(cmd.cmd_op);
    // Full stack has zero low bits, so the wrapped subtraction still lands on DEPTH-2.
    assign nos_addr = depth_q[ADDR_W-1:0] - ADDR_W'(2);

    // NOS is arriving from RAM in EXEC; RPN order is NOS op TOS.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        sum       = '0;
`ifdef RPN_MUL_EN
        prod      = '0;
`endif
        unique case (op_q)
            OpAdd: begin
                sum       = {1'b0, ram_rdata} + {1'b0, tos_q};
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
            end
            OpSub: begin
                alu_res   = ram_rdata - tos_q;
                alu_carry = ram_rdata < tos_q;
            end
`ifdef RPN_MUL_EN
            OpMul: begin
                prod      = (2*DATA_W)'(ram_rdata) * (2*DATA_W)'(tos_q);
                alu_res   = prod[DATA_W-1:0];
                alu_carry = |prod[2*DATA_W-1:DATA_W];
            end
`endif
            OpAnd:   alu_res = ram_rdata & tos_q;
            OpOr:    alu_res = ram_rdata | tos_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        depth_d = depth_q;
        tos_d   = tos_q;
        carry_d = carry_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd.cmd_valid) begin
                    op_d  = op_in;
                    err_d = ErrOk;
                    if (!MulEn && op_in == OpMul) begin
                        err_d   = ErrIllegal;
                        state_d = StDone;
                    end else begin
                        unique case (op_in)
                            OpPush, OpDup: begin
                                if (depth_q == DepthFull) begin
                                    err_d   = ErrOver;
                                    state_d = StDone;
                                end else begin
                                    addr_d  = depth_q[ADDR_W-1:0];
                                    wdata_d = (op_in == OpPush) ? cmd.cmd_data : tos_q;
                                    we_d    = 1'b1;
                                    state_d = StWr;
                                end
                            end
                            OpPop: begin
                                if (depth_q == '0) begin
                                    err_d   = ErrUnder;
                                    state_d = StDone;
                                end else if (depth_q == DepthOne) begin
                                    depth_d = '0;
                                    tos_d   = '0;
                                    state_d = StDone;
                                end else begin
                                    addr_d  = nos_addr;
                                    state_d = StRd;
                                end
                            end
                            default: begin
                                if (depth_q < DepthTwo) begin
                                    err_d   = ErrUnder;
                                    state_d = StDone;
                                end else begin
                                    addr_d  = nos_addr;
                                    state_d = StRd;
                                end
                            end
                        endcase
                    end
                end
            end
            StRd: state_d = StExec;
            StExec: begin
                if (op_q == OpPop) begin
                    tos_d   = ram_rdata;
                    depth_d = depth_q - DepthOne;
                    state_d = StDone;
                end else begin
                    wdata_d = alu_res;
                    carry_d = alu_carry;
                    we_d    = 1'b1;
                    state_d = StWr;
                end
            end
            StWr: begin
                tos_d   = wdata_q;
                depth_d = (op_q == OpPush || op_q == OpDup) ? depth_q + DepthOne
                                                            : depth_q - DepthOne;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpPush;
            err_q   <= ErrOk;
            depth_q <= '0;
            tos_q   <= '0;
            carry_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            depth_q <= depth_d;
            tos_q   <= tos_d;
            carry_q <= carry_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign cmd.cmd_ready = (state_q == StIdle) && !reset;
    assign cmd.done      = (state_q == StDone);
    assign cmd.err       = (state_q == StDone) ? err_q : ErrOk;
    assign ram_addr      = addr_q;
    assign ram_wdata     = wdata_q;
    assign ram_we        = we_q;
    assign tos           = tos_q;
    assign depth         = depth_q;
    assign carry         = carry_q;

endmodule

// File: tb/tb_rpn_stack_exec.sv
// Bench for rpn_stack_exec: directed scenarios plus random commands against a queue-based stack model.
module tb_rpn_stack_exec;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

`ifdef RPN_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b1;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_we;
    logic [DW-1:0] tos;
    logic [AW:0]   depth;
    logic          carry;
    logic [DW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;
    int stk[$];
    int m_carry  = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    rpn_stack_exec_if #(.DATA_W(DW)) bus ();

    rpn_stack_exec #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .cmd       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .tos       (tos),
        .depth     (depth),
        .carry     (carry)
    );

    always @(posedge CLOCK_50) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int nbad = 0;
        for (int i = 0; i < stk.size(); i++) if (int'(mem[i]) != stk[i]) nbad++;
        check({tag, ".tos"}, int'(tos), (stk.size() > 0) ? stk[$] : 0);
        check({tag, ".depth"}, int'(depth), stk.size());
        check({tag, ".carry"}, int'(carry), m_carry);
        check({tag, ".ram"}, nbad, 0);
    endtask

    // Reference: stack as a queue, results from plain integer arithmetic.
    task automatic model(input int op, input int data, output int e_err, output int e_lat);
        int a, b, r, c;
        e_err = 0;
        if (op == 4 && !MulEn) begin
            e_err = 3; e_lat = 1;
        end else if (op == 0 || op == 7) begin
            if (stk.size() == DEPTH) begin
                e_err = 2; e_lat = 1;
            end else begin
                stk.push_back(op == 0 ? data : (stk.size() > 0 ? stk[$] : 0));
                e_lat = 2;
            end
        end else if (op == 1) begin
            if (stk.size() == 0) begin
                e_err = 1; e_lat = 1;
            end else begin
                e_lat = (stk.size() == 1) ? 1 : 3;
                void'(stk.pop_back());
            end
        end else begin
            if (stk.size() < 2) begin
                e_err = 1; e_lat = 1;
            end else begin
                b = stk.pop_back();
                a = stk.pop_back();
                c = 0;
                case (op)
                    2: begin r = a + b; c = (r > 255); end
                    3: begin r = a - b; c = (a < b); end
                    4: begin r = a * b; c = (r > 255); end
                    5: r = a & b;
                    default: r = a | b;
                endcase
                stk.push_back(r & 255);
                m_carry = c;
                e_lat = 4;
            end
        end
    endtask

    task automatic do_cmd(input int op, input int data);
        int  e_err, e_lat, n;
        bit  seen;
        string tag;
        tag = $sformatf("op%0d", op);
        @(negedge CLOCK_50);
        check({tag, ".ready"}, int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op[2:0];
        bus.cmd_data  = data[7:0];
        model(op, data, e_err, e_lat);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 16) begin
            @(negedge CLOCK_50);
            n++;
            bus.cmd_valid = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        check({tag, ".latency"}, seen ? n : -1, e_lat);
        if (seen) begin
            check({tag, ".err"}, int'(bus.err), e_err);
            check_state(tag);
            @(negedge CLOCK_50);
            check({tag, ".done_pulse"}, int'(bus.done), 0);
            check({tag, ".err_idle"}, int'(bus.err), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge CLOCK_50);
        check("rst.ready", int'(bus.cmd_ready), 0);
        check("rst.done", int'(bus.done), 0);
        check("rst.err", int'(bus.err), 0);
        check("rst.we", int'(ram_we), 0);
        check("rst.addr", int'(ram_addr), 0);
        check("rst.wdata", int'(ram_wdata), 0);
        stk.delete();
        m_carry = 0;
        check_state("rst");
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("rst.ready_after", int'(bus.cmd_ready), 1);
    endtask

    initial begin
        int r;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_data  = '0;

        do_reset();
        do_cmd(0, 5); do_cmd(0, 3); do_cmd(2, 0);

        do_cmd(0, 3); do_cmd(0, 5); do_cmd(3, 0);
        do_cmd(0, 8'hFF); do_cmd(0, 8'h02); do_cmd(2, 0);

        do_reset();
        do_cmd(1, 0); do_cmd(0, 7); do_cmd(2, 0);

        do_reset();
        for (int i = 0; i < DEPTH; i++) do_cmd(0, i & 255);
        do_cmd(0, 8'h55); do_cmd(7, 0); do_cmd(1, 0);

        do_reset();
        do_cmd(0, 8'h10); do_cmd(0, 8'h10); do_cmd(4, 0);

        // Reset landing while an AND is in its RD cycle.
        do_reset();
        do_cmd(0, 9); do_cmd(0, 4);
        @(negedge CLOCK_50);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd5;
        @(negedge CLOCK_50);
        bus.cmd_valid = 1'b0;
        check("abort.busy", int'(bus.cmd_ready), 0);
        reset = 1'b1;
        #1;
        check("abort.depth_now", int'(depth), 0);
        do_reset();
        do_cmd(0, 8'hA5); do_cmd(1, 0);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 10);
            do_cmd((r <= 3) ? 0 : r - 3, $urandom_range(0, 255));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

endmodule
